// File: rtl/prbs5_pkg.sv
// prbs5_pkg: shared constants, FSM encoding and the next-bit predictor for the
// x^5+x^2+1 PRBS (period 31, s[k+5] = s[k] ^ s[k+2]).
package prbs5_pkg;

  localparam int unsigned PRBS_W = 5;
  // Tap positions in a history where bit i holds the sample taken (i+1) bits ago.
  localparam int unsigned TAP_HI = 4;
  localparam int unsigned TAP_LO = 2;
  // Reference seed, kept identical to the generator side.
  localparam logic [PRBS_W-1:0] PRBS_SEED = 5'b00001;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs5_state_t;

  // Next expected bit given the last five bits (bit 0 = most recent).
  function automatic logic prbs5_pred(input logic [PRBS_W-1:0] st);
    return st[TAP_HI] ^ st[TAP_LO];
  endfunction

endpackage

// File: rtl/prbs5_lol_monitor.sv
// prbs5_lol_monitor: counts errors inside fixed windows of WIN valid bits and
// requests loss of lock when LOL_THRESH errors land in one window.
// Ports:
//   clk, reset : clock, async active-high reset
//   restart    : clear window position and error tally (on entering lock)
//   sample     : a valid bit is being checked while locked
//   err        : that bit mismatched the local sequence
//   lol_c      : combinational request; this error completes the threshold
module prbs5_lol_monitor #(
  parameter int unsigned WIN        = 32,
  parameter int unsigned LOL_THRESH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic sample,
  input  logic err,
  output logic lol_c
);

  localparam int unsigned WC_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned WE_W = $clog2(LOL_THRESH + 1);

  logic [WC_W-1:0] win_cnt;
  logic [WE_W-1:0] win_err;
  logic            wrap_c;

  assign wrap_c = (win_cnt == WC_W'(WIN - 1));
  // The current error is counted before any wrap, so the last bit of a window
  // still belongs to that window.
  assign lol_c  = sample && err && (win_err == WE_W'(LOL_THRESH - 1));

  // Window position and per-window error tally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (restart) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (sample) begin
      if (wrap_c) begin
        win_cnt <= '0;
        win_err <= '0;
      end else begin
        win_cnt <= win_cnt + WC_W'(1);
        win_err <= win_err + WE_W'(err);
      end
    end
  end

endmodule

// File: rtl/prbs5_checker.sv
// prbs5_checker: receive-side checker for the 5-bit PRBS. Self-synchronises on
// the incoming stream, then free-runs a local copy and flags mismatches.
// Ports:
//   clk, reset : clock, async active-high reset
//   in_valid   : in_bit is sampled this cycle
//   in_bit     : received serial bit, oldest first
//   clear_cnt  : synchronous clear of err_count (wins over an increment)
//   locked     : high while in LOCKED
//   err_pulse  : one-cycle pulse for a mismatched sample while locked
//   sync_lost  : one-cycle pulse on LOCKED->SEARCH
//   err_count  : saturating count of locked-state errors
module prbs5_checker
  import prbs5_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned WIN        = 32,
  parameter int unsigned LOL_THRESH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_lost,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned        MC_W      = $clog2(LOCK_COUNT + 1);
  localparam int unsigned        FILL_W    = $clog2(PRBS_W + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PRBS_W);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  prbs5_state_t      state_q, state_d;
  // One register serves as received history in SEARCH and as the local LFSR
  // in LOCKED; lock loads the LFSR with the history simply by keeping it.
  logic [PRBS_W-1:0] sreg;
  logic [FILL_W-1:0] fill_q;
  logic [MC_W-1:0]   match_cnt;

  logic pred_c, cmp_c, match_c, lock_hit_c, sample_c, err_c, lol_c;
  logic locked_d, err_pulse_d, sync_lost_d;

  assign pred_c     = prbs5_pred(sreg);
  assign cmp_c      = in_valid && (state_q == SEARCH) && (fill_q == FILL_FULL);
  // An all-zero history with a zero bit is the LFSR lock-up state, not PRBS.
  assign match_c    = (in_bit == pred_c) && !((sreg == '0) && !in_bit);
  assign lock_hit_c = cmp_c && match_c && (match_cnt == MC_W'(LOCK_COUNT - 1));
  assign sample_c   = in_valid && (state_q == LOCKED);
  assign err_c      = sample_c && (in_bit != pred_c);

  prbs5_lol_monitor #(
    .WIN        (WIN),
    .LOL_THRESH (LOL_THRESH)
  ) u_lol_monitor (
    .clk     (clk),
    .reset   (reset),
    .restart (lock_hit_c),
    .sample  (sample_c),
    .err     (err_c),
    .lol_c   (lol_c)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SEARCH;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEARCH: if (lock_hit_c) state_d = LOCKED;
      LOCKED: if (lol_c)      state_d = SEARCH;
      default:                state_d = SEARCH;
    endcase
  end

  // Output decode, registered below.
  always_comb begin
    locked_d    = 1'b0;
    err_pulse_d = 1'b0;
    sync_lost_d = 1'b0;
    locked_d    = (state_d == LOCKED);
    err_pulse_d = err_c;
    sync_lost_d = (state_q == LOCKED) && lol_c;
  end

  // Registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      locked    <= locked_d;
      err_pulse <= err_pulse_d;
      sync_lost <= sync_lost_d;
    end
  end

  // History / LFSR, fill level and consecutive-match counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg      <= '0;
      fill_q    <= '0;
      match_cnt <= '0;
    end else if (in_valid) begin
      if (state_q == SEARCH) begin
        sreg <= {sreg[PRBS_W-2:0], in_bit};
        if (fill_q != FILL_FULL) fill_q    <= fill_q + FILL_W'(1);
        else if (match_c)        match_cnt <= match_cnt + MC_W'(1);
        else                     match_cnt <= '0;
      end else if (lol_c) begin
        sreg      <= '0;
        fill_q    <= '0;
        match_cnt <= '0;
      end else begin
        // Free-run on the prediction so a flipped input bit costs one error.
        sreg <= {sreg[PRBS_W-2:0], pred_c};
      end
    end
  end

  // Saturating error counter; clear wins over a coincident error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              err_count <= '0;
    else if (clear_cnt)                     err_count <= '0;
    else if (err_c && (err_count != CNT_MAX)) err_count <= err_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_prbs5_checker.sv
module tb_prbs5_checker;

  typedef struct packed {
    logic        lk;
    logic        ep;
    logic        sl;
    logic [15:0] cnt;
    logic        s_lk;
    logic        s_ep;
    logic        s_sl;
    logic [2:0]  s_cnt;
  } obs_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_bit;
  logic        clear_cnt;
  logic        locked, err_pulse, sync_lost;
  logic [15:0] err_count;
  logic        s_locked, s_err_pulse, s_sync_lost;
  logic [2:0]  s_err_count;

  int   checks;
  int   failures;
  obs_t sb[$];
  logic seq[31];
  int   gp;
  int   exp_cnt;

  prbs5_checker dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .sync_lost (sync_lost),
    .err_count (err_count)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  prbs5_checker #(.CNT_W(3)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clear_cnt (clear_cnt),
    .locked    (s_locked),
    .err_pulse (s_err_pulse),
    .sync_lost (s_sync_lost),
    .err_count (s_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {locked, err_pulse, sync_lost, err_count,
            s_locked, s_err_pulse, s_sync_lost, s_err_count};
  endfunction

  task automatic gen(output logic b);
    b  = seq[gp];
    gp = (gp + 1) % 31;
  endtask

  // Drive one cycle and queue the outputs expected after the sampling edge.
  task automatic step(input logic v, input logic b, input logic clr,
                      input logic lk, input logic ep, input logic sl, input int cnt);
    obs_t e;
    logic [2:0] sc;
    sc = (cnt > 7) ? 3'd7 : 3'(cnt);
    e  = {lk, ep, sl, 16'(cnt), lk, ep, sl, sc};
    sb.push_back(e);
    in_valid  = v;
    in_bit    = b;
    clear_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    obs_t got;
    @(posedge clk);
    @(posedge clk);
    #1;
    got = observe();
    checks++;
    if (got !== obs_t'(0)) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", got);
    end
    reset = 1'b0;
  endtask

  task automatic test_lock();
    logic b;
    obs_t got, e;
    for (int i = 0; i < 200; i++) begin
      gen(b);
      step(1'b1, b, 1'b0, (i >= 12), 1'b0, 1'b0, 0);
      got = observe();
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL lock i=%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_single_error();
    logic b, f;
    obs_t got, e;
    for (int i = 0; i < 100; i++) begin
      gen(b);
      f = (i == 10);
      if (f) exp_cnt++;
      step(1'b1, b ^ f, 1'b0, 1'b1, f, 1'b0, exp_cnt);
      got = observe();
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL single_err i=%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  // First flip lands on the last bit of a window; the next four fall in the
  // following window, so loss of sync must come on the fifth flip.
  task automatic test_lol();
    logic b, f;
    obs_t got, e;
    exp_cnt = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, exp_cnt);
    got = observe();
    e   = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL clear_idle got=%h exp=%h", got, e);
    end
    for (int o = 0; o < 40; o++) begin
      gen(b);
      f = (o <= 3) || (o == 5);
      if (f) exp_cnt++;
      step(1'b1, b ^ f, 1'b0, (o < 5) || (o >= 18), f, (o == 5), exp_cnt);
      got = observe();
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL lol o=%0d got=%h exp=%h", o, got, e);
      end
    end
  endtask

  task automatic test_no_lock();
    obs_t got, e;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(1'b1, (i >= 100), 1'b0, 1'b0, 1'b0, 1'b0, 0);
      got = observe();
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL no_lock i=%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_sparse_valid();
    logic b;
    obs_t got, e;
    do_reset();
    for (int i = 0; i < 110; i++) begin
      if (i < 20) begin
        gen(b);
        step(1'b1, b, 1'b0, (i >= 12), 1'b0, 1'b0, 0);
      end else if ((i - 20) % 3 == 0) begin
        gen(b);
        step(1'b1, b, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      end else begin
        step(1'b0, 1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 0);
      end
      got = observe();
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL sparse i=%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_reset_sat();
    logic b, f, clr;
    obs_t got, e;
    gen(b);
    exp_cnt = 1;
    step(1'b1, ~b, 1'b0, 1'b1, 1'b1, 1'b0, exp_cnt);
    got = observe();
    e   = sb.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL pre_reset_err got=%h exp=%h", got, e);
    end
    // Asynchronous reset between clock edges.
    reset = 1'b1;
    #1;
    got = observe();
    checks++;
    if (got !== obs_t'(0)) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", got);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = 0;
    // n counts locked samples since lock; three errors per window at most.
    for (int n = -13; n <= 104; n++) begin
      gen(b);
      f   = (n >= 0) && (((n % 32) >= 10 && (n % 32) <= 12) || n >= 103);
      clr = (n == 103);
      if (clr)    exp_cnt = 0;
      else if (f) exp_cnt++;
      step(1'b1, b ^ f, clr, (n >= -1), f, 1'b0, exp_cnt);
      got = observe();
      e   = sb.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL sat_clear n=%0d got=%h exp=%h", n, got, e);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    clear_cnt = 1'b0;
    checks    = 0;
    failures  = 0;
    gp        = 0;
    exp_cnt   = 0;
    seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b0; seq[3] = 1'b1; seq[4] = 1'b0;
    for (int k = 5; k < 31; k++) seq[k] = seq[k-5] ^ seq[k-3];

    test_reset();
    test_lock();
    test_single_error();
    test_lol();
    test_no_lock();
    test_sparse_valid();
    test_reset_sat();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
